// File: rtl/seven_seg_top.sv
// seven_seg_top - free-running 4-digit BCD stopwatch (SS.hh, 0.01 s steps,
// wraps at 99.99) on a multiplexed, active-low seven-segment display.
//
// Parameters:
//   COUNT_DIV  clk cycles per hundredth-of-a-second increment (>= 2)
//   SCAN_DIV   clk cycles per digit slot (>= 2)
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   seg   out  [6:0] segments a..g (bit0 = a), active-low, registered
//   dp    out  decimal point, active-low, registered (lit on digit 2)
//   an    out  [3:0] digit enables, active-low, registered (an[0] = hundredths)

// One decade of the BCD chain: advances on inc, rolls 9 -> 0 with carry out.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] d,
  output logic       co
);
  assign co = inc && (d == 4'd9);

  always_ff @(posedge clk or posedge rst)
    if (rst)      d <= '0;
    else if (inc) d <= (d >= 4'd9) ? 4'd0 : d + 4'd1;
endmodule

module seven_seg_top #(
  parameter int COUNT_DIV = 120_000,
  parameter int SCAN_DIV  = 3_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int NUM_DIG = 4;
  localparam int CW = (COUNT_DIV > 2) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam logic [CW-1:0] CMAX = CW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

  // active-high pattern, bit6 = g .. bit0 = a; anything else stays dark
  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] p;
    p = 7'h00;
    case (v)
      4'd0: p = 7'h3f;
      4'd1: p = 7'h06;
      4'd2: p = 7'h5b;
      4'd3: p = 7'h4f;
      4'd4: p = 7'h66;
      4'd5: p = 7'h6d;
      4'd6: p = 7'h7d;
      4'd7: p = 7'h07;
      4'd8: p = 7'h7f;
      4'd9: p = 7'h6f;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // count prescaler
  logic [CW-1:0] ccnt;
  logic          tick;
  assign tick = (ccnt == CMAX);

  always_ff @(posedge clk or posedge rst)
    if (rst) ccnt <= '0;
    else     ccnt <= tick ? '0 : ccnt + 1'b1;

  // BCD chain: carry ripples combinationally so all decades step on one edge
  logic [NUM_DIG-1:0][3:0] dig;
  logic [NUM_DIG:0]        cy;
  assign cy[0] = tick;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_digit u_dig (
      .clk (clk),
      .rst (rst),
      .inc (cy[g]),
      .d   (dig[g]),
      .co  (cy[g+1])
    );
  end

  // 99.99 wraps silently
  logic unused_carry;
  assign unused_carry = cy[NUM_DIG];

  // scan prescaler and digit index
  logic [SW-1:0] scnt;
  logic          sadv;
  logic [1:0]    idx;
  assign sadv = (scnt == SMAX);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scnt <= '0;
      idx  <= '0;
    end else begin
      scnt <= sadv ? '0 : scnt + 1'b1;
      if (sadv) idx <= idx + 2'd1;
    end

  // registered outputs: segments and enables switch on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= ~dec7(dig[idx]);
      dp  <= (idx != 2'd2);
    end
endmodule

// File: tb/tb_seven_seg_top.sv
// tb_seven_seg_top - scoreboard bench for seven_seg_top. Two DUTs
// (COUNT_DIV/SCAN_DIV = 10/4 and 2/2). Each display slot (one digit enable
// held low) is one DUT output transaction; expected slots are queued by the
// stimulus and popped by a monitor when the enable pattern changes.
module tb_seven_seg_top;
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
  } slot_t;

  logic clk;
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, id, got, exp);
    end
  endtask

  // hand-entered segment table, active-high, g..a
  function automatic logic [6:0] segpat(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'b0111111;
      1: p = 7'b0000110;
      2: p = 7'b1011011;
      3: p = 7'b1001111;
      4: p = 7'b1100110;
      5: p = 7'b1101101;
      6: p = 7'b1111101;
      7: p = 7'b0000111;
      8: p = 7'b1111111;
      9: p = 7'b1101111;
      default: p = 7'bxxxxxxx;
    endcase
    return p;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CD = (g == 0) ? 10 : 2;
    localparam int SD = (g == 0) ? 4  : 2;
    localparam int N1 = 6;
    localparam int N2 = (g == 0) ? 30 : 10010; // 10010 slots cross 99.99 -> 00.00

    logic       r;
    logic [6:0] sg;
    logic       d;
    logic [3:0] a;
    bit         fin = 1'b0;
    slot_t      q[$];

    seven_seg_top #(.COUNT_DIV(CD), .SCAN_DIV(SD)) dut (
      .clk (clk),
      .rst (r),
      .seg (sg),
      .dp  (d),
      .an  (a)
    );

    // Slot s (counting from release) is loaded on edge s*SD+1 and shows the
    // digit idx = s%4 of the elapsed hundredths floor(s*SD/CD) mod 10000.
    function automatic slot_t mk(input int s);
      slot_t e;
      int idx, v;
      idx = s % 4;
      v = ((s * SD) / CD) % 10000;
      for (int k = 0; k < idx; k++) v = v / 10;
      e.an  = ~(4'b0001 << idx);
      e.seg = ~segpat(v % 10);
      e.dp  = (idx != 2);
      e.len = SD;
      return e;
    endfunction

    // monitor
    logic [3:0] pan = 4'b1111;
    bit         act = 1'b0;
    bit         bad = 1'b0;
    logic [3:0] fan;
    logic [6:0] fseg;
    logic       fdp;
    int         len = 0;
    slot_t      e;

    always @(negedge clk) begin
      if (a !== pan) begin
        if (act && a !== 4'b1111) begin
          if (q.size() == 0) begin
            chk("extra_slot", g, {28'd0, fan}, 32'hf);
          end else begin
            e = q.pop_front();
            chk("slot_out", g, {20'd0, fan, fseg, fdp}, {20'd0, e.an, e.seg, e.dp});
            chk("slot_len", g, len, e.len);
            chk("onehot_an", g, {31'd0, bad}, 32'd0);
          end
        end
        act  = (a !== 4'b1111);
        fan  = a;
        fseg = sg;
        fdp  = d;
        len  = 1;
        bad  = 1'b0;
        pan  = a;
      end else if (act) begin
        len++;
      end
      if (act && $countones(~a) != 1) bad = 1'b1;
    end

    initial begin : stim
      int n;
      r = 1'b1;
      repeat (3) @(posedge clk);
      for (int pass = 0; pass < 2; pass++) begin
        n = (pass == 0) ? N1 : N2;
        for (int s = 0; s < n; s++) q.push_back(mk(s));
        @(posedge clk); #2 r = 1'b0;
        repeat (n * SD + 1) @(posedge clk);
        @(negedge clk); #1;
        chk("leftover", g, q.size(), 0);
        // mid-slot reset must blank the display without a clock edge
        @(posedge clk); #2 r = 1'b1; #1;
        chk("rst_an",  g, {28'd0, a},  32'hf);
        chk("rst_seg", g, {25'd0, sg}, 32'h7f);
        chk("rst_dp",  g, {31'd0, d},  32'd1);
        repeat (2) @(posedge clk);
        #3 chk("rst_hold_an", g, {28'd0, a}, 32'hf);
      end
      fin = 1'b1;
    end
  end

  initial begin : top
    int i;
    for (i = 0; i < 90000 && !(g_dut[0].fin && g_dut[1].fin); i++) @(posedge clk);
    if (!(g_dut[0].fin && g_dut[1].fin)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d cycles expected completion", i);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
